// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_alu : multi-cycle ALU, valid/ready request and response ports,       |
// |           single-cycle logic/arith ops plus iterative shift-add MUL.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 2);

  localparam logic [3:0] c_and = 4'b0000;
  localparam logic [3:0] c_or  = 4'b0001;
  localparam logic [3:0] c_add = 4'b0010;
  localparam logic [3:0] c_mul = 4'b0011;
  localparam logic [3:0] c_sub = 4'b0110;
  localparam logic [3:0] c_slt = 4'b0111;
  localparam logic [3:0] c_nor = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic [WIDTH-1:0] w_alu;
  logic             w_illegal;
  logic [WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0] w_mul_final;

  always_comb begin
    w_alu     = '0;
    w_illegal = 1'b0;
    case (alu_ctl)
      c_and:   w_alu = a & b;
      c_or:    w_alu = a | b;
      c_add:   w_alu = a + b;
      c_sub:   w_alu = a - b;
      c_slt:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      c_nor:   w_alu = ~(a | b);
      c_mul:   w_alu = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  // The last edge folds in two partial products so the product lands in cycle WIDTH.
  assign w_acc_step  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_final = w_acc_step + (r_mplier[1] ? {r_mcand[WIDTH-2:0], 1'b0} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            if (alu_ctl == c_mul) begin
              r_mcand  <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_count  <= '0;
              r_state  <= S_MUL;
            end else begin
              r_result  <= w_alu;
              r_zero    <= (w_alu == '0);
              r_illegal <= w_illegal;
              r_state   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_step;
          r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_count  <= r_count + 1'b1;
          if (r_count == c_cnt_last) begin
            r_result  <= w_mul_final;
            r_zero    <= (w_mul_final == '0);
            r_illegal <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_ready  = (r_state == S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_alu : self-checking bench for seq_alu with an expected-result     |
// |              queue filled at accept and drained when res_valid rises.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seq_alu;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [3:0]       alu_ctl = 4'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .alu_ctl(alu_ctl), .a(a), .b(b), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Drives one request from IDLE; returns at the falling edge of cycle 1.
  task automatic send(input logic [3:0] ctl, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic [WIDTH-1:0] er, input logic ez, input logic ei);
    @(negedge clk);
    op_valid = 1'b1; alu_ctl = ctl; a = va; b = vb;
    sb.push_back('{res: er, zero: ez, ill: ei});
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; alu_ctl = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (res_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = '{res: '1, zero: 1'bx, ill: 1'bx};
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b exp 1", op_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++; if ({result, zero, illegal} !== '0) begin errors++; $display("FAIL reset_outputs got %h/%b/%b exp 0/0/0", result, zero, illegal); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_cycle();
    logic [3:0]       t_ctl [7] = '{4'h2, 4'h0, 4'h6, 4'h6, 4'h7, 4'h7, 4'hC};
    logic [WIDTH-1:0] t_a   [7] = '{32'd7, 32'hF0F0_F0F0, 32'd5, 32'd9, 32'hFFFF_FFFF, 32'd1, 32'd0};
    logic [WIDTH-1:0] t_b   [7] = '{32'd5, 32'h0FF0_0000, 32'd7, 32'd9, 32'd1, 32'hFFFF_FFFF, 32'd0};
    logic [WIDTH-1:0] t_r   [7] = '{32'd12, 32'h00F0_0000, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF};
    logic             t_z   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int lat;
    exp_t e;
    res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(t_ctl[i], t_a[i], t_b[i], t_r[i], t_z[i], 1'b0);
      wait_valid(lat);
      e = pop_exp();
      checks++; if (lat != 1) begin errors++; $display("FAIL single_latency[%0d] got %0d exp 1", i, lat); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL single_result[%0d] got %h exp %h", i, result, e.res); end
      checks++; if (zero !== e.zero || illegal !== e.ill) begin errors++; $display("FAIL single_flags[%0d] got z=%b i=%b exp z=%b i=%b", i, zero, illegal, e.zero, e.ill); end
      @(negedge clk);
      checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL single_handshake[%0d] got rdy=%b vld=%b exp 1/0", i, op_ready, res_valid); end
    end
  endtask

  task automatic test_mul();
    logic [WIDTH-1:0] m_a [3] = '{32'd3, 32'h0001_0000, 32'hDEAD_BEEF};
    logic [WIDTH-1:0] m_b [3] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h1234_5677};
    logic [WIDTH-1:0] prod;
    int lat;
    bit busy_bad;
    exp_t e;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prod = m_a[i] * m_b[i];
      send(4'h3, m_a[i], m_b[i], prod, (prod == '0), 1'b0);
      lat = 1; busy_bad = 1'b0;
      while (res_valid !== 1'b1 && lat < 200) begin
        if (op_ready !== 1'b0) busy_bad = 1'b1;
        @(negedge clk);
        lat++;
      end
      if (op_ready !== 1'b0) busy_bad = 1'b1;
      e = pop_exp();
      checks++; if (lat != WIDTH) begin errors++; $display("FAIL mul_latency[%0d] got %0d exp %0d", i, lat, WIDTH); end
      checks++; if (busy_bad) begin errors++; $display("FAIL mul_op_ready[%0d] got high while busy exp low", i); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL mul_result[%0d] got %h exp %h", i, result, e.res); end
      checks++; if (zero !== e.zero || illegal !== e.ill) begin errors++; $display("FAIL mul_flags[%0d] got z=%b i=%b exp z=%b i=%b", i, zero, illegal, e.zero, e.ill); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    bit moved;
    exp_t e;
    res_ready = 1'b0;
    send(4'h2, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0);
    wait_valid(lat);
    e = pop_exp();
    moved = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || op_ready !== 1'b0 || result !== e.res || zero !== e.zero) moved = 1'b1;
    end
    checks++; if (result !== e.res) begin errors++; $display("FAIL bp_result got %h exp %h", result, e.res); end
    checks++; if (moved) begin errors++; $display("FAIL bp_hold got outputs changing exp stable"); end
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", res_valid, op_ready); end
  endtask

  task automatic test_held_request();
    int lat;
    bit extra;
    exp_t e;
    res_ready = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; alu_ctl = 4'h3; a = 32'd6; b = 32'd7;
    sb.push_back('{res: 32'd42, zero: 1'b0, ill: 1'b0});
    @(posedge clk);
    @(negedge clk);
    alu_ctl = 4'h2; a = 32'd100; b = 32'd23;
    wait_valid(lat);
    e = pop_exp();
    checks++; if (lat != WIDTH || result !== e.res) begin errors++; $display("FAIL held_inflight got lat=%0d res=%h exp lat=%0d res=%h", lat, result, WIDTH, e.res); end
    @(negedge clk); @(negedge clk);
    res_ready = 1'b1;
    sb.push_back('{res: 32'd123, zero: 1'b0, ill: 1'b0});
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL held_ready got %b exp 1", op_ready); end
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    e = pop_exp();
    checks++; if (res_valid !== 1'b1 || result !== e.res) begin errors++; $display("FAIL held_accept got vld=%b res=%h exp 1/%h", res_valid, result, e.res); end
    extra = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) extra = 1'b1;
    end
    checks++; if (extra) begin errors++; $display("FAIL held_once got extra res_valid exp single result"); end
  endtask

  task automatic test_illegal();
    int lat;
    exp_t e;
    res_ready = 1'b1;
    send(4'hF, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b1);
    wait_valid(lat);
    e = pop_exp();
    checks++; if (lat != 1 || result !== e.res) begin errors++; $display("FAIL illegal_result got lat=%0d res=%h exp 1/%h", lat, result, e.res); end
    checks++; if (zero !== e.zero || illegal !== e.ill) begin errors++; $display("FAIL illegal_flags got z=%b i=%b exp 1/1", zero, illegal); end
    send(4'h2, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    wait_valid(lat);
    e = pop_exp();
    checks++; if (result !== e.res || illegal !== e.ill || zero !== e.zero) begin errors++; $display("FAIL illegal_clear got res=%h i=%b exp %h/0", result, illegal, e.res); end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    exp_t e;
    res_ready = 1'b1;
    send(4'h3, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL rstmul_busy got rdy=%b exp 0", op_ready); end
    #1 rst_n = 1'b0;
    #1;
    void'(pop_exp());
    checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rstmul_handshake got rdy=%b vld=%b exp 1/0", op_ready, res_valid); end
    checks++; if ({result, zero, illegal} !== '0) begin errors++; $display("FAIL rstmul_outputs got %h/%b/%b exp 0/0/0", result, zero, illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    send(4'h2, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    wait_valid(lat);
    e = pop_exp();
    checks++; if (lat != 1 || result !== e.res) begin errors++; $display("FAIL rstmul_add got lat=%0d res=%h exp 1/%h", lat, result, e.res); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_backpressure();
    test_held_request();
    test_illegal();
    test_reset_mid_mul();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Multi-cycle ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and executes the selected operation on two WIDTH-bit operands. Operations enter through a valid/ready request port, and results leave through a valid/ready response port. Logical, add/sub, SLT and NOR complete in one cycle. MUL (low WIDTH bits) is iterative shift-add, one bit per cycle. The block sits between the decode/control stage and writeback, and stalls the pipeline through op_ready.

## Interface
- WIDTH, 32, operand and result width (≥ 2).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  request valid.
- op_ready  out  1  block can accept a request; high only in IDLE.
- alu_ctl  in  4  operation code; sampled only at accept.
- a  in  WIDTH  operand A; sampled only at accept.
- b  in  WIDTH  operand B; sampled only at accept.
- res_valid  out  1  result valid; high only in DONE.
- res_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0, registered with result.
- illegal  out  1  alu_ctl was not a supported code.

## Operation
- Supported codes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB (a−b).
  - 0111 SLT: signed a<b gives 1, else 0, zero-extended.
  - 1100 NOR.
  - 0011 MUL: low WIDTH bits of a×b; unsigned and signed give the same bits.
- Any other code is illegal: result=0, zero=1, illegal=1, one-cycle path.
- ADD and SUB are two's complement and wrap modulo 2^WIDTH. No carry or overflow output.
- Accept occurs when op_valid && op_ready on a rising edge. At accept, alu_ctl, a and b are captured. Later input changes have no effect on the in-flight operation.
- FSM states:
  - IDLE: op_ready=1.
    - On accept with a single-cycle or illegal code: compute, register result/zero/illegal, go to DONE.
    - On accept with MUL: load multiplicand=a, multiplier=b, acc=0, count=0, go to MUL.
  - MUL: each edge, if multiplier[0] then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. On the edge where count reaches WIDTH−1 (the WIDTH-th iteration), register result=acc (including that iteration), zero, illegal=0, and go to DONE.
  - DONE: res_valid=1. result, zero and illegal are held stable. If res_ready, go to IDLE on the next edge. Otherwise stay.
- op_ready=0 in MUL and DONE. Requests there are not accepted and must be held by the producer.
- No early termination of MUL (fixed latency).

## Timing
- Reset values: FSM in IDLE; op_ready=1, res_valid=0, result=0, zero=0, illegal=0; internal acc, count and operands cleared.
- Reset asserted at any time, including mid-MUL or in DONE with res_ready low, aborts the operation immediately. The result is discarded and outputs take their reset values asynchronously.
- Latency is counted from the accept cycle (cycle 0):
  - Single-cycle and illegal ops: res_valid high in cycle 1.
  - MUL: res_valid high in cycle WIDTH (cycle 32 for WIDTH=32).
- If res_ready is high in the first DONE cycle, res_valid drops and op_ready rises in the next cycle.
- Best-case throughput is one single-cycle op per 2 cycles, and one MUL per WIDTH+1 cycles.
- res_valid is never asserted for more than one transaction. Each accepted request yields exactly one result.
- Outputs are all registered; no combinational path from inputs to outputs. op_ready and res_valid are decoded from FSM state only.

## Test plan
- ADD and AND, WIDTH=32:
  - ADD, a=7, b=5, res_ready=1 → res_valid in cycle 1, result=12, zero=0, illegal=0; op_ready back high in cycle 2.
  - AND, a=0xF0F0_F0F0, b=0x0FF0_0000 → result=0x00F0_0000.
- SUB, SLT and NOR edge values:
  - SUB, a=5, b=7 → result=0xFFFF_FFFE, zero=0.
  - SUB, a=9, b=9 → result=0, zero=1.
  - SLT, a=0xFFFF_FFFF, b=1 → result=1.
  - SLT, a=1, b=0xFFFF_FFFF → result=0.
  - NOR, a=0, b=0 → result=0xFFFF_FFFF.
- MUL latency and wrap:
  - a=3, b=0xFFFF_FFFF → result=0xFFFF_FFFD; res_valid first high in cycle 32; op_ready low during cycles 1..32.
  - a=0x0001_0000, b=0x0001_0000 → result=0, zero=1.
- Backpressure:
  - Hold res_ready=0 for 5 cycles after res_valid rises → result, zero and res_valid stay constant.
  - op_valid held high with different alu_ctl/a/b throughout → ignored until op_ready rises, then accepted once.
- Illegal code alu_ctl=1111, a=b=0x1234 → cycle 1: result=0, zero=1, illegal=1. The next legal op clears illegal.
- Reset mid-MUL: assert rst_n=0 in cycle 10 of a MUL → outputs immediately at reset values. After release, ADD 1+1 → result=2 in cycle 1 with no stale MUL result.
